// File: rtl/prbs_checker.sv
// Receive-side PRBS-15 checker: validates an n-times-repeated 32-bit preamble, then counts bit errors.
// Optional macro PRBS_CHECKER_SELF_SYNC_EN: derive the LFSR state from the first 8 PRBS bytes instead of the seed.
module prbs_checker #(
    parameter int ERR_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    input  logic [7:0]       n,
    input  logic [31:0]      in,
    output logic             locked,
    output logic             pattern_err,
    output logic             byte_err,
    output logic [ERR_W-1:0] bit_err_cnt,
    output logic [CNT_W-1:0] byte_cnt
);

    typedef enum logic [1:0] {
        ST_PAT  = 2'd0,
        ST_PRBS = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    state_t           state_reg;
    logic [1:0]       idx_reg;
    logic [7:0]       rep_reg;
    logic [14:0]      lfsr_reg;
    logic             locked_reg;
    logic             pattern_err_reg;
    logic             byte_err_reg;
    logic [ERR_W-1:0] bit_err_cnt_reg;
    logic [CNT_W-1:0] byte_cnt_reg;

`ifdef PRBS_CHECKER_SELF_SYNC_EN
    logic [2:0]       sync_cnt_reg;
    logic [7:0]       b0_reg;
    logic [14:0]      l7;
    assign l7 = {b0_reg, in_byte[6:0]};
`endif

    logic [7:0]       pat_exp;
    logic [7:0]       diff;
    logic [3:0]       pop;
    logic [ERR_W+3:0] err_sum;
    logic [ERR_W-1:0] err_next;
    logic [CNT_W-1:0] cnt_next;
    logic [14:0]      lfsr_step;
    logic             last_rep;

    always_comb begin
        pat_exp = in[31:24];
        case (idx_reg)
            2'd0:    pat_exp = in[31:24];
            2'd1:    pat_exp = in[23:16];
            2'd2:    pat_exp = in[15:8];
            default: pat_exp = in[7:0];
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_diff
            assign diff[gi] = in_byte[gi] ^ lfsr_reg[gi];
        end
    endgenerate

    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'd0, diff[i]};
        end
    end

    // Widen before adding so the sum can never wrap past the saturation point.
    always_comb begin
        err_sum  = {4'd0, bit_err_cnt_reg} + {{ERR_W{1'b0}}, pop};
        err_next = (err_sum > {4'd0, {ERR_W{1'b1}}}) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
        cnt_next = (&byte_cnt_reg) ? byte_cnt_reg : byte_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign lfsr_step = {lfsr_reg[13:0], lfsr_reg[14] ^ lfsr_reg[13]};
    // n-1 in 8 bits, so n=0 asks for 256 repetitions.
    assign last_rep  = (rep_reg == 8'(n - 8'd1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= ST_PAT;
            idx_reg         <= 2'd0;
            rep_reg         <= 8'd0;
            lfsr_reg        <= in[14:0];
            locked_reg      <= 1'b0;
            pattern_err_reg <= 1'b0;
            byte_err_reg    <= 1'b0;
            bit_err_cnt_reg <= '0;
            byte_cnt_reg    <= '0;
`ifdef PRBS_CHECKER_SELF_SYNC_EN
            sync_cnt_reg    <= 3'd0;
            b0_reg          <= 8'd0;
`endif
        end else if (!in_valid) begin
            state_reg    <= ST_PAT;
            idx_reg      <= 2'd0;
            rep_reg      <= 8'd0;
            locked_reg   <= 1'b0;
            byte_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_PAT: begin
                    byte_err_reg <= 1'b0;
                    if (in_byte == pat_exp) begin
                        if (idx_reg == 2'd3) begin
                            idx_reg <= 2'd0;
                            if (last_rep) begin
                                rep_reg <= 8'd0;
`ifdef PRBS_CHECKER_SELF_SYNC_EN
                                state_reg    <= ST_SYNC;
                                sync_cnt_reg <= 3'd0;
`else
                                state_reg  <= ST_PRBS;
                                locked_reg <= 1'b1;
`endif
                            end else begin
                                rep_reg <= rep_reg + 8'd1;
                            end
                        end else begin
                            idx_reg <= idx_reg + 2'd1;
                        end
                    end else begin
                        pattern_err_reg <= 1'b1;
                        rep_reg         <= 8'd0;
                        idx_reg         <= (in_byte == in[31:24]) ? 2'd1 : 2'd0;
                    end
                end
                ST_PRBS: begin
                    lfsr_reg        <= lfsr_step;
                    byte_cnt_reg    <= cnt_next;
                    bit_err_cnt_reg <= err_next;
                    byte_err_reg    <= |diff;
                    locked_reg      <= 1'b1;
                end
`ifdef PRBS_CHECKER_SELF_SYNC_EN
                ST_SYNC: begin
                    // Byte 7 plus byte 0 reconstructs the full 15-bit state after byte 7.
                    if (sync_cnt_reg == 3'd0) begin
                        b0_reg <= in_byte;
                    end
                    if (sync_cnt_reg == 3'd7) begin
                        lfsr_reg   <= {l7[13:0], l7[14] ^ l7[13]};
                        state_reg  <= ST_PRBS;
                        locked_reg <= 1'b1;
                    end
                    sync_cnt_reg <= sync_cnt_reg + 3'd1;
                end
`endif
                default: begin
                    state_reg <= ST_PAT;
                    idx_reg   <= 2'd0;
                    rep_reg   <= 8'd0;
                end
            endcase
        end
    end

    assign locked      = locked_reg;
    assign pattern_err = pattern_err_reg;
    assign byte_err    = byte_err_reg;
    assign bit_err_cnt = bit_err_cnt_reg;
    assign byte_cnt    = byte_cnt_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// Randomized self-checking bench for prbs_checker: a byte-level reference model plus directed literal checks.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic [7:0]  n;
    logic [31:0] pat;

    logic        a_locked, a_perr, a_berr;
    logic [15:0] a_bits;
    logic [31:0] a_bytes;
    logic        b_locked, b_perr, b_berr;
    logic [3:0]  b_bits;
    logic [5:0]  b_bytes;

    always #5 clk = ~clk;

    prbs_checker #(.ERR_W(16), .CNT_W(32)) u_a (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_byte(in_byte), .n(n), .in(pat),
        .locked(a_locked), .pattern_err(a_perr), .byte_err(a_berr),
        .bit_err_cnt(a_bits), .byte_cnt(a_bytes)
    );

    prbs_checker #(.ERR_W(4), .CNT_W(6)) u_b (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_byte(in_byte), .n(n), .in(pat),
        .locked(b_locked), .pattern_err(b_perr), .byte_err(b_berr),
        .bit_err_cnt(b_bits), .byte_cnt(b_bytes)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, exp);
        end
    endtask

    function automatic int adv(input int s);
        return ((s << 1) & 32'h7ffe) | (((s >> 14) ^ (s >> 13)) & 1);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference model: preamble progress is a single count of consecutive matched bytes.
    int m_ready = 0;
    int m_state, m_prog, m_lfsr, m_locked, m_perr, m_berr, m_bits, m_bytes, m_k, m_b0;

    always @(posedge clk) begin
        int reps, e, l7;
        cycle++;
        if (rst) begin
            m_ready = 1; m_state = 0; m_prog = 0; m_lfsr = int'(pat[14:0]);
            m_locked = 0; m_perr = 0; m_berr = 0; m_bits = 0; m_bytes = 0; m_k = 0; m_b0 = 0;
        end else if (m_ready != 0) begin
            if (!in_valid) begin
                m_state = 0; m_prog = 0; m_locked = 0; m_berr = 0;
            end else if (m_state == 0) begin
                reps = (n == 8'd0) ? 256 : int'(n);
                e = int'((pat >> (8 * (3 - (m_prog % 4))))) & 8'hff;
                m_berr = 0;
                if (int'(in_byte) == e) begin
                    m_prog++;
                    if (m_prog == 4 * reps) begin
                        m_prog = 0;
`ifdef PRBS_CHECKER_SELF_SYNC_EN
                        m_state = 2; m_k = 0;
`else
                        m_state = 1; m_locked = 1;
`endif
                    end
                end else begin
                    m_perr = 1;
                    m_prog = (in_byte == pat[31:24]) ? 1 : 0;
                end
            end else if (m_state == 1) begin
                e = m_lfsr & 8'hff;
                m_bits  = m_bits + $countones(int'(in_byte) ^ e);
                m_bytes = m_bytes + 1;
                m_berr  = (int'(in_byte) != e) ? 1 : 0;
                m_lfsr  = adv(m_lfsr);
            end else begin
                if (m_k == 0) m_b0 = int'(in_byte);
                if (m_k == 7) begin
                    l7 = ((m_b0 << 7) | (int'(in_byte) & 8'h7f)) & 32'h7fff;
                    m_lfsr = adv(l7); m_state = 1; m_locked = 1;
                end
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready != 0) begin
            check("a_locked", 64'(a_locked), 64'(m_locked));
            check("a_pattern_err", 64'(a_perr), 64'(m_perr));
            check("a_byte_err", 64'(a_berr), 64'(m_berr));
            check("a_bit_err_cnt", 64'(a_bits), 64'(imin(m_bits, 65535)));
            check("a_byte_cnt", 64'(a_bytes), 64'(m_bytes));
            check("b_locked", 64'(b_locked), 64'(m_locked));
            check("b_pattern_err", 64'(b_perr), 64'(m_perr));
            check("b_byte_err", 64'(b_berr), 64'(m_berr));
            check("b_bit_err_cnt", 64'(b_bits), 64'(imin(m_bits, 15)));
            check("b_byte_cnt", 64'(b_bytes), 64'(imin(m_bytes, 63)));
        end
    end

    int tx_lfsr;

    task automatic drive(input bit v, input logic [7:0] b);
        @(negedge clk); #1;
        in_valid = v;
        in_byte  = b;
    endtask

    task automatic peek();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_pre(input int reps, input int bad_rep, input int bad_idx);
        logic [7:0] b;
        logic [31:0] w;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < 4; i++) begin
                w = pat >> (8 * (3 - i));
                b = w[7:0];
                if (r == bad_rep && i == bad_idx) b = 8'hFF;
                drive(1'b1, b);
            end
        end
    endtask

    task automatic send_prbs(input int cnt, input int flip_at, input logic [7:0] flip, input bit comp);
        logic [7:0] b;
        for (int k = 0; k < cnt; k++) begin
            b = tx_lfsr[7:0];
            if (comp) b = ~b;
            if (k == flip_at) b = b ^ flip;
            drive(1'b1, b);
            tx_lfsr = adv(tx_lfsr);
        end
    endtask

    initial begin
        int len, nb;
        logic [7:0] b, mask;
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; n = 8'd2; pat = 32'hA5C30001;
        @(negedge clk); #1;
        rst = 1'b0;

`ifdef PRBS_CHECKER_SELF_SYNC_EN
        pat = 32'hA5C30000; n = 8'd2; do_reset(); tx_lfsr = 1;
        send_pre(2, -1, 0); peek();
        check("sync_not_locked", 64'(a_locked), 64'd0);
        send_prbs(8, -1, 8'h00, 1'b0); peek();
        check("sync_locked", 64'(a_locked), 64'd1);
        check("sync_byte_cnt0", 64'(a_bytes), 64'd0);
        send_prbs(5, -1, 8'h00, 1'b0); peek();
        check("sync_byte_cnt5", 64'(a_bytes), 64'd5);
        check("sync_no_err", 64'(a_bits), 64'd0);
        drive(1'b0, 8'h00);
`else
        // Clean lock and PRBS run from seed 0x0001.
        pat = 32'hA5C30001; n = 8'd2; do_reset(); tx_lfsr = 1;
        send_pre(2, -1, 0); peek();
        check("t1_locked", 64'(a_locked), 64'd1);
        send_prbs(9, -1, 8'h00, 1'b0); peek();
        check("t1_byte_cnt", 64'(a_bytes), 64'd9);
        check("t1_bit_err", 64'(a_bits), 64'd0);
        check("t1_pattern_err", 64'(a_perr), 64'd0);
        check("t1_last_byte", 64'(in_byte), 64'h00);
        drive(1'b0, 8'h00);

        // Single-bit error in the third PRBS byte.
        do_reset(); tx_lfsr = 1;
        send_pre(2, -1, 0);
        send_prbs(3, 2, 8'h01, 1'b0); peek();
        check("t2_byte_err", 64'(a_berr), 64'd1);
        check("t2_sent_05", 64'(in_byte), 64'h05);
        send_prbs(6, -1, 8'h00, 1'b0); peek();
        check("t2_byte_err_clear", 64'(a_berr), 64'd0);
        check("t2_bit_err", 64'(a_bits), 64'd1);
        check("t2_locked", 64'(a_locked), 64'd1);
        drive(1'b0, 8'h00);

        // Corrupted first repetition: rep restarts, pattern_err sticks.
        do_reset();
        send_pre(1, 0, 2);
        send_pre(1, -1, 0); peek();
        check("t3_not_locked", 64'(a_locked), 64'd0);
        send_pre(1, -1, 0); peek();
        check("t3_locked", 64'(a_locked), 64'd1);
        check("t3_pattern_err", 64'(a_perr), 64'd1);
        drive(1'b0, 8'h00);

        // n=0 means 256 repetitions.
        n = 8'd0; do_reset();
        send_pre(255, -1, 0); peek();
        check("t4_255_not_locked", 64'(a_locked), 64'd0);
        send_pre(1, -1, 0); peek();
        check("t4_256_locked", 64'(a_locked), 64'd1);
        drive(1'b0, 8'h00);

        // Frame drop and relock, then reset mid-PRBS.
        n = 8'd2; do_reset(); tx_lfsr = 1;
        send_pre(2, -1, 0);
        send_prbs(5, -1, 8'h00, 1'b0);
        drive(1'b0, 8'h00); peek();
        check("t5_unlocked", 64'(a_locked), 64'd0);
        send_pre(2, -1, 0);
        send_prbs(5, -1, 8'h00, 1'b0); peek();
        check("t5_relocked", 64'(a_locked), 64'd1);
        check("t5_byte_cnt", 64'(a_bytes), 64'd10);
        check("t5_bit_err", 64'(a_bits), 64'd0);
        @(negedge clk); #1;
        rst = 1'b1; peek();
        check("t5_rst_locked", 64'(a_locked), 64'd0);
        check("t5_rst_byte_cnt", 64'(a_bytes), 64'd0);
        @(negedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;

        // Complemented bytes drive the narrow counter to saturation.
        do_reset(); tx_lfsr = 1;
        send_pre(2, -1, 0);
        send_prbs(2, -1, 8'h00, 1'b1); peek();
        check("t6_b_sat", 64'(b_bits), 64'd15);
        check("t6_a_16", 64'(a_bits), 64'd16);
        send_prbs(1, -1, 8'h00, 1'b1); peek();
        check("t6_b_sticks", 64'(b_bits), 64'd15);
        drive(1'b0, 8'h00);
`endif

        // Randomized frames: corrupt preambles, bit flips, drops and occasional resets.
        do_reset(); tx_lfsr = int'(pat[14:0]);
        for (int f = 0; f < 40; f++) begin
            n = 8'($urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) begin
                pat = $urandom;
                do_reset();
`ifdef PRBS_CHECKER_SELF_SYNC_EN
                tx_lfsr = $urandom_range(1, 32767);
`else
                tx_lfsr = int'(pat[14:0]);
`endif
            end
            if ($urandom_range(0, 5) == 0) begin
                send_pre(int'(n), $urandom_range(0, int'(n) - 1), $urandom_range(0, 3));
            end
            if ($urandom_range(0, 9) == 0) begin
                send_pre(1, -1, 0);
                drive(1'b0, 8'h00);
            end
            send_pre(int'(n), -1, 0);
            len = $urandom_range(0, 40);
            nb  = 0;
            while (nb < len) begin
                b = tx_lfsr[7:0];
                if ($urandom_range(0, 9) == 0) begin
                    mask = 8'($urandom_range(1, 255));
                    b = b ^ mask;
                end
                drive(1'b1, b);
                tx_lfsr = adv(tx_lfsr);
                nb++;
            end
            drive(1'b0, 8'h00);
        end

        drive(1'b0, 8'h00);
        peek();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the team's byte-wide PRBS generator. The generator sends a 32-bit pattern word n times, MSB byte first, then a PRBS-15 byte stream (x^15 + x^14 + 1, 1-bit shift per byte).
- This block checks the preamble, switches to the PRBS phase, and then counts bit errors against its own LFSR replica.
- It sits at the far end of the link, driven by the delayed generator output plus a frame-valid qualifier.

Parameters:
- ERR_W, 16: width of the saturating bit-error counter.
- CNT_W, 32: width of the saturating checked-byte counter.

Ports:
- CLK  input  1  clock. Reset is synchronous and active-high, sampled only on the rising edge of CLK.
- RST  input  1  synchronous active-high reset.
- in_valid  input  1  frame qualifier; also qualifies in_byte. Low means frame aborted.
- in_byte  input  8  received byte.
- n  input  8  preamble repetition count; 0 means 256.
- in  input  32  pattern word; in[14:0] is the LFSR seed.
- locked  output  1  high while in the PRBS phase.
- pattern_err  output  1  sticky preamble-mismatch flag.
- byte_err  output  1  one-cycle pulse: the last checked PRBS byte mismatched.
- bit_err_cnt  output  ERR_W  saturating count of mismatched PRBS bits.
- byte_cnt  output  CNT_W  saturating count of PRBS bytes compared.

Behaviour:
- Reset (RST=1 at an edge):
  - State goes to PAT; idx=0, rep=0.
  - LFSR loads in[14:0].
  - All outputs go to 0.
  - Reset takes priority over everything.
- States: PAT and PRBS (plus SYNC with the optional feature).
- A byte is consumed on every edge with in_valid=1 and RST=0. All outputs are registered and visible the cycle after the consuming edge.
- in_valid=0 in any state:
  - State goes to PAT; idx=0, rep=0; locked=0; byte_err=0.
  - LFSR, pattern_err and both counters hold.
  - The LFSR is reloaded only by RST.
- PAT:
  - Expected byte is in[31:24], in[23:16], in[15:8], in[7:0] for idx = 0..3.
  - Match with idx<3: idx++.
  - Match with idx=3: idx=0.
    - If rep == n-1 (8-bit wrap, so n=0 means 256 repetitions): go to PRBS, rep=0, locked=1 next cycle.
    - Otherwise rep++.
  - Mismatch: pattern_err<=1 (sticky until RST), rep=0.
    - idx<=1 if in_byte==in[31:24]; otherwise idx<=0.
- PRBS:
  - Expected byte is LFSR[7:0].
  - LFSR <= {LFSR[13:0], LFSR[14]^LFSR[13]}.
  - byte_cnt++ (saturates at all-ones).
  - bit_err_cnt += popcount(in_byte ^ LFSR[7:0]); saturates at 2^ERR_W-1 and never wraps.
  - byte_err <= (in_byte != LFSR[7:0]).
  - Stays in PRBS until in_valid=0 or RST.
- Changes to in or n during a frame take effect on the next comparison. There is no latching.
- Simultaneous in_valid=0 and RST=1: reset wins.

Optional Feature:
- Macro: PRBS_CHECKER_SELF_SYNC_EN.
- Defined:
  - Preamble completion goes to SYNC, not PRBS; the seed input is ignored for checking.
  - In SYNC, capture b0 = the first PRBS byte. Count the following bytes without comparing them.
  - On the 8th PRBS byte (b7):
    - Set L7 = {b0, b7[6:0]}.
    - Set LFSR <= {L7[13:0], L7[14]^L7[13]}.
    - Go to PRBS; locked=1.
  - Comparison starts with byte 8. byte_cnt excludes bytes 0..7.
  - in_valid=0 in SYNC returns to PAT.
- Not defined: there is no SYNC state, and the seed behaviour is exactly as described in Behaviour.

Test Plan:
1. Pattern 0xA5C30001, n=2, clean stream of A5 C3 00 01 A5 C3 00 01 then 01 02 04 08 10 20 40 80 00 -> locked=1 after the 8th preamble byte; byte_cnt=9; bit_err_cnt=0; pattern_err=0.
2. Same as test 1 but the 3rd PRBS byte is 0x05 instead of 0x04 -> one byte_err pulse; bit_err_cnt=1; lock holds.
3. Preamble byte 2 corrupted to 0xFF on the 1st repetition, then 2 clean repetitions -> pattern_err=1 sticky; locked only after 2 clean words (rep reset observed).
4. n=0 -> lock only after 256 clean repetitions (1024 bytes); not after 255 repetitions.
5. in_valid dropped for 1 cycle mid-PRBS, then the generator resends the preamble and continues the LFSR -> locked=0 then relocks; counters retained; no new errors. RST asserted mid-PRBS -> all outputs 0 next cycle.
6. Force bit_err_cnt near saturation (ERR_W=4, send 0xFF complements) -> count sticks at 15. With PRBS_CHECKER_SELF_SYNC_EN and seed=0 but transmitter seeded 0x0001 -> locks after 8 PRBS bytes; 0 errors.
